neuron_vote_window: RTL
=======================

# neuron_vote_window

Downstream decision stage for the neuron network. Samples the registered 1-bit output of the second-layer neuron over a fixed window of enabled cycles, counts how many samples were 1, and forms a majority vote. Each window result goes into a one-entry output buffer and is offered over a valid/ready handshake, so a slow consumer does not stall sampling. Results the consumer has not taken in time are dropped and reported with a sticky flag.

## Interface
Parameters:
- WINDOW, 16: enabled samples per window; legal range 2..255.
- VOTE_THRESH, 8: vote is 1 when count > VOTE_THRESH (strict, same comparison sense as the neuron threshold).
- CW, $clog2(WINDOW+1): count width, derived; must not be overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  sample enable; spike_in is counted only in cycles where en=1.
- clear  in  1  synchronous abort of the current window; the output buffer is not affected.
- spike_in  in  1  neuron output being voted on.
- out_valid  out  1  output buffer holds an untaken result.
- out_ready  in  1  consumer accepts the result; a transfer occurs when out_valid & out_ready.
- out_count  out  CW  number of 1 samples in the buffered window (0..WINDOW).
- out_vote  out  1  buffered decision (out_count > VOTE_THRESH).
- overrun  out  1  sticky; set when a completed window is dropped.

## Operation
- Internal state:
  - idx: sample index, 0..WINDOW-1.
  - acc: running count, CW bits.
  - buffer: out_count, out_vote, out_valid.
  - overrun flag.
- Two-state FSM, ACCUM and DONE.
  - ACCUM is the normal state.
  - DONE lasts exactly one cycle and performs the buffer load.
- ACCUM, cycle with en=1 and clear=0:
  - acc += spike_in.
  - If idx == WINDOW-1: latch final = acc + spike_in into a result register, then idx←0, acc←0, go to DONE.
  - Otherwise idx += 1.
- ACCUM, cycle with en=0: no change.
- DONE:
  - Buffer is free (out_valid=0), or is being drained this cycle (out_valid & out_ready): load out_count←final and out_vote←(final > VOTE_THRESH); out_valid←1.
  - Otherwise: discard final, set overrun←1, buffer unchanged.
  - Sampling continues during DONE: if en=1, spike_in is counted as sample 0 of the next window. Idx/acc are already cleared, so no sample is lost.
  - Always return to ACCUM.
- Transfer with no load in the same cycle: out_valid←0. out_count and out_vote keep their last value.
- clear=1: idx←0, acc←0. A pending DONE still completes, because its result is already latched. Clear overrides en in the same cycle.
- Arithmetic:
  - acc cannot exceed WINDOW, so it never wraps; CW is sized to hold WINDOW.
  - The vote compare is unsigned, and VOTE_THRESH is zero-extended to CW.
- overrun clears only on reset.

## Timing
- Reset (rst_n=0 at a clk edge): state←ACCUM, idx←0, acc←0, out_valid←0, out_count←0, out_vote←0, overrun←0.
  - Reset mid-window discards the partial count.
  - Reset discards any buffered result.
- Latency:
  - Final sample edge → DONE.
  - DONE edge → out_valid=1.
  - Result is visible 2 cycles after the cycle the last sample is presented.
- While out_valid=1 and out_ready=0: out_count and out_vote are held stable.
- Minimum window spacing is WINDOW cycles, which is at least 2. At most one DONE is ever pending, so a second result can never arrive before the first is resolved.
- Simultaneous drain and load in DONE: the new result is accepted with no overrun, and out_valid stays 1 with no gap.
- out_ready is ignored while out_valid=0.

## Test plan
- Basic majority:
  - Stimulus: rst, WINDOW=16, VOTE_THRESH=8, en=1 constantly, spike_in=1 for 9 samples then 0 for 7, out_ready=1.
  - Response: out_valid pulses 1 cycle, 2 cycles after sample 16, with out_count=9 and out_vote=1.
- Threshold boundary:
  - Stimulus: exactly 8 ones in a window.
  - Response: out_count=8, out_vote=0.
- Full and empty extremes:
  - Stimulus: all-1 window, then all-0 window.
  - Response: out_count=16 with vote 1, then out_count=0 with vote 0; acc never wraps.
- Gated sampling and clear:
  - Stimulus: en toggles every other cycle. Then clear is asserted after 5 samples, followed by 16 more ones.
  - Response: only enabled samples are counted. The post-clear result is 16, with out_valid 2 cycles after the 16th enabled sample.
- Backpressure and overrun:
  - Stimulus: out_ready=0 across two full windows, then out_ready=1.
  - Response: the first result is held stable, the second is dropped, overrun=1 and stays set. With out_ready=1, a third window completing in the same cycle as a drain loads with out_valid continuously 1.
- Reset mid-operation:
  - Stimulus: rst_n=0 at sample 10 while out_valid=1.
  - Response: all outputs are 0 next cycle. The next window counts from 0 and its result needs 16 fresh samples.

Source files
------------

// File: rtl/neuron_vote_window.sv
// Majority-vote window over the registered second-layer neuron output.
// Window results go through a one-entry valid/ready buffer; results dropped while it is full set a sticky overrun flag.
module neuron_vote_window #(
  parameter int WINDOW      = 16,
  parameter int VOTE_THRESH = 8,
  parameter int CW          = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clear,
  input  logic          spike_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_vote,
  output logic          overrun
);

  // state | meaning
  // ACCUM | counting enabled samples of the current window
  // DONE  | one cycle: offer the latched window result to the output buffer
  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);
  localparam logic [CW-1:0] THRESH   = CW'(VOTE_THRESH);

  state_t        state;
  logic [CW-1:0] idx;
  logic [CW-1:0] acc;
  logic [CW-1:0] final_count;
  logic [CW-1:0] acc_next;
  logic          sample;
  logic          last_sample;
  logic          buf_free;

  assign acc_next    = acc + {{(CW-1){1'b0}}, spike_in};
  assign sample      = en && !clear;
  assign last_sample = sample && (idx == LAST_IDX);
  assign buf_free    = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ACCUM;
      idx         <= '0;
      acc         <= '0;
      final_count <= '0;
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_vote    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Sampling runs in both states; idx is 0 in DONE, so a window can never end there.
      if (clear) begin
        idx <= '0;
        acc <= '0;
      end else if (sample) begin
        if (last_sample) begin
          final_count <= acc_next;
          idx         <= '0;
          acc         <= '0;
        end else begin
          idx <= idx + 1'b1;
          acc <= acc_next;
        end
      end

      case (state)
        ACCUM: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (last_sample) state <= DONE;
        end
        DONE: begin
          if (buf_free) begin
            out_count <= final_count;
            out_vote  <= (final_count > THRESH);
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
